gshare_fetch_predictor: RTL and testbench

//  Parametrised fetch-stage branch predictor. It combines a tagged direct-mapped BTB, a gshare PHT
//  of CTR_W-bit saturating counters and a speculative global history register (GHR) with

---
 rtl/bp_pkg.sv | 19 +
 rtl/bp_btb.sv | 59 +++++
 rtl/gshare_fetch_predictor.sv | 93 +++++++++
 tb/tb_gshare_fetch_predictor.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared defaults and saturating-counter helpers for the gshare fetch predictor.
package bp_pkg;

  localparam int unsigned PC_W_DEF      = 32;
  localparam int unsigned BTB_IDX_W_DEF = 4;
  localparam int unsigned PHT_IDX_W_DEF = 6;
  localparam int unsigned GHR_W_DEF     = 4;
  localparam int unsigned CTR_W_DEF     = 2;

  // Weakly not-taken: the largest value whose MSB is still clear.
  function automatic int unsigned ctr_init(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int unsigned ctr_max(input int unsigned w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Tagged direct-mapped branch target buffer: synchronous clear of valid bits,
// combinational read port, one write port.
module bp_btb
  import bp_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned IDX_W = BTB_IDX_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] rd_pc,
  output logic            rd_hit,
  output logic [PC_W-1:0] rd_target,
  input  logic            wr_en,
  input  logic [PC_W-1:0] wr_pc,
  input  logic [PC_W-1:0] wr_target
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned TAG_W   = PC_W - IDX_W;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [PC_W-1:0]    target_d [ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;

  assign rd_idx    = rd_pc[IDX_W-1:0];
  assign wr_idx    = wr_pc[IDX_W-1:0];
  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_pc[PC_W-1:IDX_W]);
  assign rd_target = target_q[rd_idx];

  // NOTE: every always_comb output is defaulted first, so no path can infer a latch.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (wr_en) begin
      valid_d[wr_idx]  = 1'b1;
      tag_d[wr_idx]    = wr_pc[PC_W-1:IDX_W];
      target_d[wr_idx] = wr_target;
    end
  end

  // NOTE: sequential state uses non-blocking assignment; only the valid bits are reset,
  // tag/target contents are meaningless until their valid bit is set.
  always_ff @(posedge clk) begin
    if (!reset) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: rtl/gshare_fetch_predictor.sv
// Fetch-stage predictor: BTB + gshare PHT of saturating counters + speculative GHR
// with repair on mispredict. Lookup is combinational; training lands at the next edge.
module gshare_fetch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned BTB_IDX_W = BTB_IDX_W_DEF,
  parameter int unsigned PHT_IDX_W = PHT_IDX_W_DEF,
  parameter int unsigned GHR_W     = GHR_W_DEF,
  parameter int unsigned CTR_W     = CTR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             f_valid,
  input  logic             f_stall,
  input  logic [PC_W-1:0]  f_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             u_valid,
  input  logic [PC_W-1:0]  u_pc,
  input  logic [GHR_W-1:0] u_ghr,
  input  logic             u_taken,
  input  logic [PC_W-1:0]  u_target,
  input  logic             u_mispredict
);

  localparam int unsigned      PHT_N    = 1 << PHT_IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));
  localparam logic [CTR_W-1:0] CTR_MAX  = CTR_W'(ctr_max(CTR_W));

  if (GHR_W > PHT_IDX_W) begin : g_bad_ghr_w
    $error("gshare_fetch_predictor: GHR_W must not exceed PHT_IDX_W");
  end

  logic [CTR_W-1:0]     pht_q [PHT_N];
  logic [CTR_W-1:0]     pht_d [PHT_N];
  logic [GHR_W-1:0]     ghr_q, ghr_d;
  logic [PHT_IDX_W-1:0] f_idx, u_idx;
  logic [CTR_W-1:0]     f_ctr, u_ctr;
  logic                 btb_hit;
  logic [PC_W-1:0]      btb_target;

  bp_btb #(
    .PC_W  (PC_W),
    .IDX_W (BTB_IDX_W)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .rd_pc     (f_pc),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .wr_en     (u_valid & u_taken),
    .wr_pc     (u_pc),
    .wr_target (u_target)
  );

  assign f_idx       = f_pc[PHT_IDX_W-1:0] ^ PHT_IDX_W'(ghr_q);
  assign u_idx       = u_pc[PHT_IDX_W-1:0] ^ PHT_IDX_W'(u_ghr);
  assign f_ctr       = pht_q[f_idx];
  assign u_ctr       = pht_q[u_idx];
  assign pred_hit    = btb_hit;
  assign pred_taken  = btb_hit & f_ctr[CTR_W-1];
  assign pred_target = btb_hit ? btb_target : '0;
  assign pred_ghr    = ghr_q;

  always_comb begin
    pht_d = pht_q;
    if (u_valid) begin
      if (u_taken && (u_ctr != CTR_MAX))          pht_d[u_idx] = u_ctr + 1'b1;
      else if (!u_taken && (u_ctr != '0))         pht_d[u_idx] = u_ctr - 1'b1;
    end
  end

  // Repair outranks the speculative shift; shift-and-or also covers GHR_W == 1.
  always_comb begin
    ghr_d = ghr_q;
    if (u_valid && u_mispredict)             ghr_d = (u_ghr << 1) | GHR_W'(u_taken);
    else if (f_valid && !f_stall && btb_hit) ghr_d = (ghr_q << 1) | GHR_W'(pred_taken);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ghr_q <= '0;
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= CTR_INIT;
    end else begin
      ghr_q <= ghr_d;
      pht_q <= pht_d;
    end
  end

endmodule

// File: tb/tb_gshare_fetch_predictor.sv
// Directed + random bench for gshare_fetch_predictor against an array-based reference model.
module tb_gshare_fetch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_valid, f_stall;
  logic [31:0] f_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic [3:0]  pred_ghr;
  logic        u_valid;
  logic [31:0] u_pc;
  logic [3:0]  u_ghr;
  logic        u_taken;
  logic [31:0] u_target;
  logic        u_mispredict;

  int errors = 0;
  int checks = 0;

  // Reference model: plain arrays indexed by integer arithmetic on the PC.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  int unsigned m_tgt   [16];
  int          m_pht   [64];
  int unsigned m_ghr;

  always #5 clk = ~clk;

  gshare_fetch_predictor dut (
    .clk          (clk),
    .reset        (reset),
    .f_valid      (f_valid),
    .f_stall      (f_stall),
    .f_pc         (f_pc),
    .pred_hit     (pred_hit),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .pred_ghr     (pred_ghr),
    .u_valid      (u_valid),
    .u_pc         (u_pc),
    .u_ghr        (u_ghr),
    .u_taken      (u_taken),
    .u_target     (u_target),
    .u_mispredict (u_mispredict)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    for (int i = 0; i < 64; i++) m_pht[i] = 1;
    m_ghr = 0;
  endtask

  // Checks the current-cycle prediction against the model, then advances one clock.
  task automatic cycle(input string tag);
    int unsigned fpc, upc, bi, pi, ui, exp_tgt;
    bit          hit, tk;
    fpc = f_pc;
    upc = u_pc;
    bi  = fpc % 16;
    hit = m_valid[bi] && (m_tag[bi] == fpc / 16);
    pi  = (fpc % 64) ^ m_ghr;
    tk  = hit && (m_pht[pi] >= 2);
    exp_tgt = hit ? m_tgt[bi] : 0;
    #1;
    chk({tag, ".hit"},    32'(pred_hit),   32'(hit));
    chk({tag, ".taken"},  32'(pred_taken), 32'(tk));
    chk({tag, ".target"}, pred_target,     exp_tgt);
    chk({tag, ".ghr"},    32'(pred_ghr),   m_ghr);
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      if (u_valid) begin
        ui = (upc % 64) ^ int'(u_ghr);
        if (u_taken) begin
          if (m_pht[ui] < 3) m_pht[ui]++;
          m_valid[upc % 16] = 1'b1;
          m_tag[upc % 16]   = upc / 16;
          m_tgt[upc % 16]   = u_target;
        end else if (m_pht[ui] > 0) begin
          m_pht[ui]--;
        end
      end
      if (u_valid && u_mispredict)         m_ghr = (int'(u_ghr) * 2 + int'(u_taken)) % 16;
      else if (f_valid && !f_stall && hit) m_ghr = (m_ghr * 2 + int'(tk)) % 16;
    end
    #1;
  endtask

  task automatic upd(input int unsigned pc, input int unsigned gh, input bit tk,
                     input int unsigned tgt, input bit mis);
    u_valid = 1'b1; u_pc = pc; u_ghr = 4'(gh); u_taken = tk; u_target = tgt; u_mispredict = mis;
  endtask

  initial begin
    reset = 1'b0; f_valid = 1'b0; f_stall = 1'b0; f_pc = '0;
    u_valid = 1'b0; u_pc = '0; u_ghr = '0; u_taken = 1'b0; u_target = '0; u_mispredict = 1'b0;

    // Reset state
    @(posedge clk); #1;
    model_reset();
    f_pc = 32'h05; #1;
    chk("rst.hit", 32'(pred_hit), 0);
    chk("rst.taken", 32'(pred_taken), 0);
    chk("rst.target", pred_target, 0);
    chk("rst.ghr", 32'(pred_ghr), 0);
    reset = 1'b1;

    // Train 0x05 taken twice, then lookup hits and predicts taken
    upd(32'h05, 0, 1'b1, 32'h20, 1'b0);
    cycle("train1");
    cycle("train2");
    u_valid = 1'b0; f_valid = 1'b1; f_pc = 32'h05; #1;
    chk("look.hit", 32'(pred_hit), 1);
    chk("look.taken", 32'(pred_taken), 1);
    chk("look.target", pred_target, 32'h20);
    cycle("look");
    chk("look.ghr_after", 32'(pred_ghr), 32'b0001);

    // Same BTB index, different tag: miss and GHR holds
    f_pc = 32'h15; #1;
    chk("alias.hit", 32'(pred_hit), 0);
    chk("alias.taken", 32'(pred_taken), 0);
    cycle("alias");
    chk("alias.ghr_after", 32'(pred_ghr), 32'b0001);

    // Prepare PHT[5^3] strongly taken, repair GHR to 0011
    f_valid = 1'b0;
    upd(32'h05, 3, 1'b1, 32'h20, 1'b0);
    cycle("prep1");
    cycle("prep2");
    upd(32'h30, 1, 1'b1, 32'h44, 1'b1);
    cycle("repair_to_3");
    chk("repair.ghr", 32'(pred_ghr), 32'b0011);

    // Repair beats a same-cycle speculative taken shift
    f_valid = 1'b1; f_pc = 32'h05;
    upd(32'h09, 32'b1010, 1'b0, 0, 1'b1);
    #1;
    chk("prio.taken", 32'(pred_taken), 1);
    cycle("prio");
    chk("prio.ghr_after", 32'(pred_ghr), 32'b0100);

    // Saturate down at 0, then one taken -> weak NT
    f_valid = 1'b0;
    upd(32'h05, 3, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("sat_dn");
    chk("sat.floor", 32'(dut.pht_q[6]), 0);
    upd(32'h05, 3, 1'b1, 32'h20, 1'b0);
    cycle("sat_up");
    upd(32'h20, 1, 1'b1, 32'h60, 1'b1);
    cycle("repair_to_3b");

    // Stalled hit lookup: not-taken prediction, GHR holds
    u_valid = 1'b0; f_valid = 1'b1; f_stall = 1'b1; f_pc = 32'h05; #1;
    chk("stall.hit", 32'(pred_hit), 1);
    chk("stall.taken", 32'(pred_taken), 0);
    cycle("stall");
    chk("stall.ghr_after", 32'(pred_ghr), 32'b0011);
    f_stall = 1'b0;

    // Reset mid-training overrides the update
    upd(32'h05, 0, 1'b1, 32'h77, 1'b1);
    reset = 1'b0;
    cycle("rst_mid");
    reset = 1'b1; u_valid = 1'b0; #1;
    chk("rst_mid.hit", 32'(pred_hit), 0);
    chk("rst_mid.ghr", 32'(pred_ghr), 0);

    // Random traffic over a small PC space so entries collide and hit
    for (int n = 0; n < 600; n++) begin
      reset        = ($urandom_range(0, 59) != 0);
      f_valid      = $urandom_range(0, 3) != 0;
      f_stall      = $urandom_range(0, 4) == 0;
      f_pc         = ($urandom_range(0, 3) << 6) | $urandom_range(0, 63);
      u_valid      = $urandom_range(0, 1);
      u_pc         = ($urandom_range(0, 3) << 6) | $urandom_range(0, 63);
      u_ghr        = 4'($urandom);
      u_taken      = $urandom_range(0, 1);
      u_target     = $urandom;
      u_mispredict = $urandom_range(0, 3) == 0;
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
